// File: rtl/ldm_pkg.sv
// Shared types and constants for the LDM scan controller.
// Build option: define LDM_SCAN_BLANK_EN to compile in the per-line blanking state.
package ldm_pkg;

  localparam int LDM_LINES     = 16;
  localparam int LDM_ADDR_W    = 4;
  localparam int LDM_HOLD_W    = 8;
  localparam int LDM_BLANK_CYC = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_BLANK = 2'd3
  } ldm_state_e;

endpackage

// File: rtl/ldm_line_timer.sv
// Loadable down-counter that times the per-line hold and the blanking gap.
// Counts down to zero and then stays there until the next load.
module ldm_line_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic [W-1:0] o_value,
  output logic         o_expired
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_value   = r_count;
  assign o_expired = (r_count == '0);

endmodule

// File: rtl/ldm_scan_ctrl.sv
// Sequencing controller for the 16x16 LDM serializer: block load, line stepping, hold/blank.
// Build option: LDM_SCAN_BLANK_EN adds a BLANK state after every line.
module ldm_scan_ctrl
  import ldm_pkg::*;
#(
  parameter int LINES  = LDM_LINES,
  parameter int ADDR_W = LDM_ADDR_W,
  parameter int HOLD_W = LDM_HOLD_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              blk_valid,
  output logic              blk_ready,
  input  logic [HOLD_W-1:0] hold_cycles,
  output logic              pixel_data_en,
  output logic [ADDR_W-1:0] ldm_addr,
  output logic              line_valid,
  input  logic              line_ready,
  input  logic              abort,
  output logic              blank,
  output logic              frame_done,
  output logic              busy,
  output logic [1:0]        dbg_state,
  output logic [HOLD_W-1:0] dbg_timer
);

  // Handshakes: a block transfers on a rising edge where blk_valid & blk_ready,
  // a line transfers on a rising edge where line_valid & line_ready; once raised,
  // ready/valid on our side stay up until the transfer or an abort.

`ifdef LDM_SCAN_BLANK_EN
  localparam int BLANK_CYC = LDM_BLANK_CYC;
`endif

  ldm_state_e        r_state;
  ldm_state_e        w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [HOLD_W-1:0] r_hold;
  logic [HOLD_W-1:0] w_hold_nxt;
  logic              r_frame_done;
  logic              w_done_nxt;
  logic              w_adv;
  logic              w_is_last;
  logic              w_tmr_load;
  logic [HOLD_W-1:0] w_tmr_val;
  logic              w_tmr_dec;
  logic [HOLD_W-1:0] w_tmr_value;
  logic              w_tmr_expired;
`ifdef LDM_SCAN_BLANK_EN
  logic              r_last;
  logic              w_last_nxt;
`endif

  assign w_is_last = (r_addr == ADDR_W'(LINES - 1));

  ldm_line_timer #(
    .W (HOLD_W)
  ) u_line_timer (
    .clk        (clk),
    .rstn       (rstn),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_dec      (w_tmr_dec),
    .o_value    (w_tmr_value),
    .o_expired  (w_tmr_expired)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_hold_nxt  = r_hold;
    w_done_nxt  = 1'b0;
    w_adv       = 1'b0;
    w_tmr_load  = 1'b0;
    w_tmr_val   = r_hold - 1'b1;
    w_tmr_dec   = 1'b0;
`ifdef LDM_SCAN_BLANK_EN
    w_last_nxt  = r_last;
`endif

    case (r_state)
      ST_IDLE: begin
        w_addr_nxt = '0;
        if (blk_valid) begin
          w_hold_nxt  = hold_cycles;
          w_state_nxt = ST_SHOW;
        end
      end
      ST_SHOW: begin
        if (line_ready) begin
          if (r_hold != '0) begin
            // Loaded with H-1 so HOLD lasts exactly H cycles ending on expiry.
            w_tmr_load  = 1'b1;
            w_tmr_val   = r_hold - 1'b1;
            w_state_nxt = ST_HOLD;
          end else begin
            w_adv = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (w_tmr_expired) begin
          w_adv = 1'b1;
        end else begin
          w_tmr_dec = 1'b1;
        end
      end
`ifdef LDM_SCAN_BLANK_EN
      ST_BLANK: begin
        if (w_tmr_expired) begin
          if (r_last) begin
            w_state_nxt = ST_IDLE;
            w_addr_nxt  = '0;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_SHOW;
          end
        end else begin
          w_tmr_dec = 1'b1;
        end
      end
`endif
      default: begin
        w_state_nxt = ST_IDLE;
        w_addr_nxt  = '0;
      end
    endcase

    if (w_adv) begin
`ifdef LDM_SCAN_BLANK_EN
      // Address moves on entry to BLANK so it only ever changes while blanked.
      w_state_nxt = ST_BLANK;
      w_tmr_load  = 1'b1;
      w_tmr_val   = HOLD_W'(BLANK_CYC - 1);
      w_last_nxt  = w_is_last;
      if (!w_is_last) begin
        w_addr_nxt = r_addr + ADDR_W'(1);
      end
`else
      if (w_is_last) begin
        w_state_nxt = ST_IDLE;
        w_addr_nxt  = '0;
        w_done_nxt  = 1'b1;
      end else begin
        w_state_nxt = ST_SHOW;
        w_addr_nxt  = r_addr + ADDR_W'(1);
      end
`endif
    end

    // Abort beats everything, including a line handshake in the same cycle.
    if (abort && (r_state != ST_IDLE)) begin
      w_state_nxt = ST_IDLE;
      w_addr_nxt  = '0;
      w_done_nxt  = 1'b0;
      w_tmr_load  = 1'b0;
      w_tmr_dec   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_hold       <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_addr       <= w_addr_nxt;
      r_hold       <= w_hold_nxt;
      r_frame_done <= w_done_nxt;
    end
  end

`ifdef LDM_SCAN_BLANK_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_last <= 1'b0;
    end else begin
      r_last <= w_last_nxt;
    end
  end

  assign blank = (r_state == ST_BLANK);
`else
  assign blank = 1'b0;
`endif

  assign blk_ready     = (r_state == ST_IDLE);
  assign pixel_data_en = blk_valid & blk_ready;
  assign line_valid    = (r_state == ST_SHOW);
  assign busy          = (r_state != ST_IDLE);
  assign ldm_addr      = r_addr;
  assign frame_done    = r_frame_done;
  assign dbg_state     = r_state;
  assign dbg_timer     = w_tmr_value;

endmodule

// File: tb/tb_ldm_scan_ctrl.sv
// Directed bench for ldm_scan_ctrl; expectations adapt to LDM_SCAN_BLANK_EN.
module tb_ldm_scan_ctrl;

`ifdef LDM_SCAN_BLANK_EN
  localparam int BLK = 2;
`else
  localparam int BLK = 0;
`endif

  logic       clk = 1'b0;
  logic       rstn;
  logic       blk_valid;
  logic       blk_ready;
  logic [7:0] hold_cycles;
  logic       pixel_data_en;
  logic [3:0] ldm_addr;
  logic       line_valid;
  logic       line_ready;
  logic       abort;
  logic       blank;
  logic       frame_done;
  logic       busy;
  logic [1:0] dbg_state;
  logic [7:0] dbg_timer;

  int n_checks = 0;
  int n_err    = 0;

  // {line_valid, blank, busy, blk_ready, frame_done, ldm_addr}
  logic [8:0] obs;
  assign obs = {line_valid, blank, busy, blk_ready, frame_done, ldm_addr};

  ldm_scan_ctrl dut (
    .clk           (clk),
    .rstn          (rstn),
    .blk_valid     (blk_valid),
    .blk_ready     (blk_ready),
    .hold_cycles   (hold_cycles),
    .pixel_data_en (pixel_data_en),
    .ldm_addr      (ldm_addr),
    .line_valid    (line_valid),
    .line_ready    (line_ready),
    .abort         (abort),
    .blank         (blank),
    .frame_done    (frame_done),
    .busy          (busy),
    .dbg_state     (dbg_state),
    .dbg_timer     (dbg_timer)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; blk_valid = 1'b0; hold_cycles = '0; line_ready = 1'b0; abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (obs !== 9'b0_0_0_1_0_0000) begin n_err++; $display("FAIL reset_outputs got=%b want=%b", obs, 9'b0_0_0_1_0_0000); end
    n_checks++; if (pixel_data_en !== 1'b0) begin n_err++; $display("FAIL reset_pde got=%b want=0", pixel_data_en); end
    n_checks++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL reset_state got=%0d want=0", dbg_state); end
    rstn = 1'b1;
    step();
    n_checks++; if (obs !== 9'b0_0_0_1_0_0000) begin n_err++; $display("FAIL reset_after_release got=%b want=%b", obs, 9'b0_0_0_1_0_0000); end
  endtask

  task automatic test_basic();
    logic [8:0] exp;
    hold_cycles = 8'd0; line_ready = 1'b1; blk_valid = 1'b1;
    #1;
    n_checks++; if (pixel_data_en !== 1'b1) begin n_err++; $display("FAIL basic_pde_accept got=%b want=1", pixel_data_en); end
    step();
    blk_valid = 1'b0;
    hold_cycles = 8'd77;  // must not affect the frame already accepted
    for (int l = 0; l < 16; l++) begin
      exp = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'(l)};
      n_checks++; if (obs !== exp) begin n_err++; $display("FAIL basic_show line=%0d got=%b want=%b", l, obs, exp); end
      n_checks++; if (pixel_data_en !== 1'b0) begin n_err++; $display("FAIL basic_pde_frame line=%0d got=%b want=0", l, pixel_data_en); end
      step();
      for (int b = 0; b < BLK; b++) begin
        exp = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'((l == 15) ? 15 : l + 1)};
        n_checks++; if (obs !== exp) begin n_err++; $display("FAIL basic_blank line=%0d got=%b want=%b", l, obs, exp); end
        step();
      end
    end
    n_checks++; if (obs !== 9'b0_0_0_1_1_0000) begin n_err++; $display("FAIL basic_done got=%b want=%b", obs, 9'b0_0_0_1_1_0000); end
    step();
    n_checks++; if (obs !== 9'b0_0_0_1_0_0000) begin n_err++; $display("FAIL basic_idle got=%b want=%b", obs, 9'b0_0_0_1_0_0000); end
  endtask

  task automatic test_hold();
    logic [8:0] exp;
    int cyc;
    hold_cycles = 8'd3; line_ready = 1'b1; blk_valid = 1'b1;
    step();
    blk_valid = 1'b0; hold_cycles = 8'd0;
    cyc = 1;
    for (int l = 0; l < 16; l++) begin
      exp = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'(l)};
      n_checks++; if (obs !== exp) begin n_err++; $display("FAIL hold_show line=%0d got=%b want=%b", l, obs, exp); end
      step(); cyc++;
      for (int h = 0; h < 3; h++) begin
        exp = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'(l)};
        n_checks++; if (obs !== exp) begin n_err++; $display("FAIL hold_wait line=%0d h=%0d got=%b want=%b", l, h, obs, exp); end
        step(); cyc++;
      end
      for (int b = 0; b < BLK; b++) begin
        step(); cyc++;
      end
    end
    n_checks++; if (frame_done !== 1'b1) begin n_err++; $display("FAIL hold_done got=%b want=1", frame_done); end
    n_checks++; if (cyc !== 16 * (4 + BLK) + 1) begin n_err++; $display("FAIL hold_frame_len got=%0d want=%0d", cyc, 16 * (4 + BLK) + 1); end
    step();
  endtask

  task automatic test_backpressure();
    int cyc;
    int stall;
    bit seen;
    hold_cycles = 8'd0; line_ready = 1'b1; blk_valid = 1'b1;
    step();
    blk_valid = 1'b0;
    cyc = 1; stall = 0; seen = 1'b0;
    while (!frame_done && cyc < 300) begin
      if (stall == 0 && line_valid && ldm_addr == 4'd7) begin
        line_ready = 1'b0;
        stall = 1;
      end else if (stall >= 1 && stall <= 5) begin
        seen = 1'b1;
        n_checks++; if (obs !== 9'b1_0_1_0_0_0111) begin n_err++; $display("FAIL bp_stall n=%0d got=%b want=%b", stall, obs, 9'b1_0_1_0_0_0111); end
        if (stall == 5) line_ready = 1'b1;
        stall++;
      end
      step(); cyc++;
    end
    n_checks++; if (!seen || frame_done !== 1'b1) begin n_err++; $display("FAIL bp_done got=%b want=1 (stall_seen=%0d)", frame_done, seen); end
    n_checks++; if (cyc !== 17 + 5 + 16 * BLK) begin n_err++; $display("FAIL bp_frame_len got=%0d want=%0d", cyc, 17 + 5 + 16 * BLK); end
    line_ready = 1'b1;
    step();
  endtask

  task automatic test_abort();
    int cyc;
    hold_cycles = 8'd0; line_ready = 1'b1; blk_valid = 1'b1;
    step();
    blk_valid = 1'b0;
    cyc = 0;
    while (!(line_valid && ldm_addr == 4'd9) && cyc < 200) begin
      step(); cyc++;
    end
    n_checks++; if (cyc >= 200) begin n_err++; $display("FAIL abort_reach_line9 got=timeout want=line 9"); end
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_checks++; if (obs !== 9'b0_0_0_1_0_0000) begin n_err++; $display("FAIL abort_idle got=%b want=%b", obs, 9'b0_0_0_1_0_0000); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (obs !== 9'b0_0_0_1_0_0000) begin n_err++; $display("FAIL abort_no_done i=%0d got=%b want=%b", i, obs, 9'b0_0_0_1_0_0000); end
    end
    // abort in IDLE must not block a block handshake
    abort = 1'b1; blk_valid = 1'b1;
    #1;
    n_checks++; if (pixel_data_en !== 1'b1) begin n_err++; $display("FAIL abort_idle_pde got=%b want=1", pixel_data_en); end
    step();
    blk_valid = 1'b0;
    n_checks++; if (obs !== 9'b1_0_1_0_0_0000) begin n_err++; $display("FAIL abort_idle_ignored got=%b want=%b", obs, 9'b1_0_1_0_0_0000); end
    step();
    abort = 1'b0;
    n_checks++; if (obs !== 9'b0_0_0_1_0_0000) begin n_err++; $display("FAIL abort_show got=%b want=%b", obs, 9'b0_0_0_1_0_0000); end
  endtask

  task automatic test_back_to_back();
    int pde_cnt;
    hold_cycles = 8'd0; line_ready = 1'b1; blk_valid = 1'b1;
    #1;
    n_checks++; if (pixel_data_en !== 1'b1) begin n_err++; $display("FAIL b2b_first_pde got=%b want=1", pixel_data_en); end
    step();
    pde_cnt = 0;
    for (int i = 0; i < 16 * (1 + BLK); i++) begin
      if (pixel_data_en) pde_cnt++;
      step();
    end
    n_checks++; if (pde_cnt !== 0) begin n_err++; $display("FAIL b2b_pde_in_frame got=%0d want=0", pde_cnt); end
    n_checks++; if ({frame_done, blk_ready, pixel_data_en} !== 3'b111) begin n_err++; $display("FAIL b2b_accept_in_done got=%b want=111", {frame_done, blk_ready, pixel_data_en}); end
    step();
    n_checks++; if (obs !== 9'b1_0_1_0_0_0000) begin n_err++; $display("FAIL b2b_second_frame got=%b want=%b", obs, 9'b1_0_1_0_0_0000); end
    blk_valid = 1'b0; abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

`ifdef LDM_SCAN_BLANK_EN
  task automatic test_blank();
    int cyc;
    int nblank;
    logic [3:0] prev_addr;
    hold_cycles = 8'd0; line_ready = 1'b1; blk_valid = 1'b1;
    step();
    blk_valid = 1'b0;
    cyc = 1; nblank = 0; prev_addr = 4'd0;
    while (!frame_done && cyc < 200) begin
      if (blank) nblank++;
      n_checks++; if (ldm_addr !== prev_addr && blank !== 1'b1) begin n_err++; $display("FAIL blank_addr_change cyc=%0d got=blank %b want=1", cyc, blank); end
      prev_addr = ldm_addr;
      step(); cyc++;
    end
    n_checks++; if (nblank !== 32) begin n_err++; $display("FAIL blank_count got=%0d want=32", nblank); end
    n_checks++; if (cyc !== 49) begin n_err++; $display("FAIL blank_frame_len got=%0d want=49", cyc); end
    step();
  endtask
`endif

  task automatic test_reset_mid();
    hold_cycles = 8'd0; line_ready = 1'b1; blk_valid = 1'b1;
    step();
    blk_valid = 1'b0;
    repeat (5) step();
    rstn = 1'b0;
    #1;
    n_checks++; if (obs !== 9'b0_0_0_1_0_0000) begin n_err++; $display("FAIL midreset_outputs got=%b want=%b", obs, 9'b0_0_0_1_0_0000); end
    step();
    rstn = 1'b1;
    step();
    n_checks++; if (obs !== 9'b0_0_0_1_0_0000) begin n_err++; $display("FAIL midreset_after got=%b want=%b", obs, 9'b0_0_0_1_0_0000); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_backpressure();
    test_abort();
    test_back_to_back();
`ifdef LDM_SCAN_BLANK_EN
    test_blank();
`endif
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/ldm_scan_ctrl.md
# ldm_scan_ctrl

Sequencing controller for the 16×16 LDM block serializer.
- Accepts one 256-bit pixel block per handshake and pulses the serializer's load enable.
- Steps the 4-bit line address 0→15, presenting each 16-bit line to the downstream LED-driver interface under a valid/ready handshake, with a programmable hold (and optional blanking) between lines.
- Sits between the pixel-block source and the serializer; owns its `PIXEL_DATA_EN` and `LDM_ADDR` inputs.

## Interface
- `LINES`, 16, lines per block; fixed by the serializer.
- `ADDR_W`, 4, line address width.
- `HOLD_W`, 8, width of the per-line hold count.
- `BLANK_CYC`, 2, blanking cycles per line (used only with the macro).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `blk_valid`  in  1  upstream block available; pixel data is presented directly to the serializer.
- `blk_ready`  out  1  controller can accept a block.
- `hold_cycles`  in  HOLD_W  idle cycles after each line transfer; sampled at block accept.
- `pixel_data_en`  out  1  serializer load enable.
- `ldm_addr`  out  ADDR_W  serializer line select.
- `line_valid`  out  1  selected line is valid downstream.
- `line_ready`  in  1  downstream accepts the line.
- `abort`  in  1  synchronous frame abort.
- `blank`  out  1  driver blanking strobe.
- `frame_done`  out  1  one-cycle pulse after the last line completes.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, SHOW, HOLD, BLANK (macro only).
- **IDLE**
  - `blk_ready`=1.
  - `pixel_data_en` = `blk_valid & blk_ready`, combinational, so the serializer captures on the handshake edge.
  - On the handshake: latch `hold_cycles`, set `ldm_addr`=0, go to SHOW.
- **SHOW**
  - `line_valid`=1.
  - On `line_ready`:
    - If the latched hold ≠ 0: load the timer and go to HOLD.
    - Else go to next-line handling.
- **HOLD**
  - `line_valid`=0; timer counts down.
  - When the timer reaches 0: go to next-line handling.
- **Next-line handling**
  - With the macro: enter BLANK.
  - Without the macro: if `ldm_addr` = LINES-1, go to IDLE and pulse `frame_done`; else increment `ldm_addr` and go to SHOW.
- **BLANK**
  - `blank`=1 for BLANK_CYC cycles.
  - `ldm_addr` increments on the first BLANK cycle.
  - Last-line check is done at the end of BLANK.
- **Address rule:** `ldm_addr` never wraps within a frame. Increment from 15 does not occur; the FSM returns to IDLE, where `ldm_addr` is held at 0.
- **`abort`**
  - In any non-IDLE state: next state is IDLE, `ldm_addr`=0, no `frame_done`.
  - If coincident with `line_ready` in SHOW, the line counts as transferred but abort still wins.
  - Ignored in IDLE.
- **`blk_valid` outside IDLE:** ignored (`blk_ready`=0); the serializer contents remain stable for the whole frame.
- **`line_ready` outside SHOW:** ignored.

## Timing
- **Reset values:** state IDLE, `blk_ready`=1, `ldm_addr`=0, and `line_valid`=`blank`=`frame_done`=`busy`=0.
  - `pixel_data_en`=0 unless `blk_valid` is asserted during reset.
  - The serializer is in reset then, so this is harmless.
- **Load latency:** `line_valid` for line 0 rises 1 cycle after the accept edge, when the serializer output is valid.
- **Per-line cycles** with `line_ready` held high: 1 + H, plus BLANK_CYC with the macro.
- **Full frame** without the macro, `line_ready`=1, H=0: 16 SHOW cycles.
  - `frame_done` is high in the first IDLE cycle after them.
  - A new block can be accepted in that same cycle.
- **Reset mid-frame:** immediate return to reset values; no `frame_done`.
- `frame_done` is a registered output; all other outputs except `pixel_data_en` are state decodes.

## Configuration
- Macro: `LDM_SCAN_BLANK_EN`.
- **Defined:** BLANK state is compiled in; `blank` pulses BLANK_CYC cycles after every line, including the last.
- **Undefined:** BLANK is absent, `blank` is tied to 0, and the port remains present.

## Structure
- **`ldm_pkg`:** FSM state enum, `LDM_LINES`=16, `LDM_ADDR_W`=4.
- **Sub-module `ldm_line_timer`:** loadable HOLD_W down-counter with `load`, `value`, and `expired` (count==0) outputs. It is reused for the blank count with the macro.

## Test plan
- **Basic frame:** reset; block with H=0 and `line_ready`=1.
  - `pixel_data_en` is 1 for one cycle.
  - `ldm_addr` steps 0..15 on consecutive cycles.
  - `frame_done` pulses at cycle 17 after accept.
- **Hold:** H=3 → each line shows `line_valid` for 1 cycle then 3 low cycles; frame length is 64 cycles.
- **Backpressure:** `line_ready` low for 5 cycles on line 7 → `ldm_addr` stays at 7 with `line_valid` high; the frame completes 5 cycles late.
- **Abort:** abort at line 9 coincident with `line_ready` → IDLE next cycle, `ldm_addr`=0, no `frame_done`, `blk_ready`=1.
- **Back-to-back and busy-ignore:**
  - `blk_valid` held high through the frame → exactly one `pixel_data_en` per frame.
  - The next accept lands in the `frame_done` cycle.
- **Blanking** (`LDM_SCAN_BLANK_EN`, BLANK_CYC=2, H=0) → 3 cycles per line; `blank` is high 2 cycles after each line; the address changes only during `blank`.
